// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_stage
// Description : Decode/operand-fetch stage. It holds the 32x32 register file
//               and the write-back port, selects the register or immediate
//               operand, and feeds a one-entry valid/ready pipeline register
//               that has stall and flush handling.
//               Optional macro OPERAND_BYPASS_EN forwards the same-cycle
//               write-back data to the register read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stage #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic        imm_signed,
  input  logic [1:0]  op_in,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] c,
  output logic [1:0]  op,
  output logic [4:0]  rd_out
);

  // R[0] is hardwired to zero, so it has no storage.
  logic [31:0] rf_q [1:REG_COUNT-1];

  logic        rs_hit;
  logic        rt_hit;
  logic        wb_hit;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic        accept;

  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d;
  logic [31:0] c_q, c_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;

  assign rs_hit = (rs_addr != 5'd0) && (32'(rs_addr) < REG_COUNT);
  assign rt_hit = (rt_addr != 5'd0) && (32'(rt_addr) < REG_COUNT);
  assign wb_hit = wb_en && (wb_addr != 5'd0) && (32'(wb_addr) < REG_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_hit) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_hit) rs_val = rf_q[rs_addr];
    if (rt_hit) rt_val = rf_q[rt_addr];
`ifdef OPERAND_BYPASS_EN
    if (wb_hit && (wb_addr == rs_addr)) rs_val = wb_data;
    if (wb_hit && (wb_addr == rt_addr)) rt_val = wb_data;
`endif
  end

  assign imm_ext  = imm_signed ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Operands are snapshots: data registers change only on accept.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    c_d     = c_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = rs_val;
      c_d     = use_imm ? imm_ext : rt_val;
      op_d    = op_in;
      rd_d    = rd_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      c_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      c_q     <= c_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign c         = c_q;
  assign op        = op_q;
  assign rd_out    = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stage
// Description : Scoreboard bench for operand_stage; directed vectors push
//               expected results, a monitor pops them on each consumed output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm;
  logic        use_imm;
  logic        imm_signed;
  logic [1:0]  op_in;
  logic [4:0]  rd_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] c;
  logic [1:0]  op;
  logic [4:0]  rd_out;

`ifdef OPERAND_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BYP_A = 32'h0000_0003;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] c;
    logic [1:0]  op;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  operand_stage #(.REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .imm_signed(imm_signed), .op_in(op_in), .rd_in(rd_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .c(c), .op(op),
    .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: an output is consumed when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=a:%h c:%h required=none", a, c);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_a",  a, e.a);
        check("sb_c",  c, e.c);
        check("sb_op", 32'(op), 32'(e.op));
        check("sb_rd", 32'(rd_out), 32'(e.rd));
      end
    end
  end

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im,
                       input logic ui, input logic sg, input logic [1:0] o, input logic [4:0] rd,
                       input logic [31:0] ea, input logic [31:0] ec, input bit push);
    int n = 0;
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; imm = im;
    use_imm = ui; imm_signed = sg; op_in = o; rd_in = rd;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back('{a: ea, c: ec, op: o, rd: rd});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs_addr = '0; rt_addr = '0; imm = '0;
    use_imm = 1'b0; imm_signed = 1'b0; op_in = '0; rd_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_c", c, 32'd0);
    check("rst_op_rd", {25'd0, op, rd_out}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b1; #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b0;
    @(posedge clk); #1;

    // Basic register read and immediate extension
    wb_write(5'd5, 32'h0000_000A);
    wb_write(5'd6, 32'h0000_0001);
    issue(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 2'd0, 5'd3, 32'h0000_000A, 32'h0000_0001, 1);
    issue(5'd6, 5'd0, 16'hFFFF, 1'b1, 1'b1, 2'd1, 5'd2, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    issue(5'd6, 5'd0, 16'hFFFF, 1'b1, 1'b0, 2'd2, 5'd4, 32'h0000_0001, 32'h0000_FFFF, 1);
    issue(5'd0, 5'd5, 16'h7FFF, 1'b1, 1'b1, 2'd3, 5'd31, 32'h0, 32'h0000_7FFF, 1);
    wb_write(5'd0, 32'h1234_5678);
    issue(5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 2'd1, 5'd1, 32'h0, 32'h0, 1);
    @(posedge clk); #1;

    // Stall: A held, B waits, write-back to R5 must not refresh A
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 2'd0, 5'd7, 32'h0000_000A, 32'h0000_0001, 1);
    in_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd6; use_imm = 1'b0; op_in = 2'd2; rd_in = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_000F;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_a", a, 32'h0000_000A);
      check("stall_c_rd", {c[26:0], rd_out}, {27'd1, 5'd7});
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{a: 32'h0000_000F, c: 32'h0000_0001, op: 2'd2, rd: 5'd9});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush a held instruction while another is offered
    out_ready = 1'b0;
    issue(5'd6, 5'd6, 16'h0000, 1'b0, 1'b0, 2'd1, 5'd10, 32'h0, 32'h0, 0);
    in_valid = 1'b1; rs_addr = 5'd5; rd_in = 5'd11; flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0055;
    #1;
    check("flush_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("flush_dropped", 32'(out_valid), 32'd0);
    issue(5'd8, 5'd5, 16'h0000, 1'b0, 1'b0, 2'd3, 5'd12, 32'h0000_0055, 32'h0000_000F, 1);

    // Same-cycle write-back and read
    wb_write(5'd7, 32'h0000_0003);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hFFFF_FFFF;
    issue(5'd7, 5'd0, 16'h0001, 1'b1, 1'b0, 2'd0, 5'd13, BYP_A, 32'h0000_0001, 1);
    wb_en = 1'b0;
    issue(5'd7, 5'd0, 16'h0002, 1'b1, 1'b0, 2'd0, 5'd14, 32'hFFFF_FFFF, 32'h0000_0002, 1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 2'd1, 5'd15, 32'h0, 32'h0, 0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_a", a, 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 2'd2, 5'd16, 32'h0, 32'h0, 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
